reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//   Multi-entry register storage: one synchronous write port, two asynchronous read ports.
//   Storage bits are edge-triggered flip-flops. Each flip-flop is two level-sensitive latches in master-slave form.
//   Sits between the CPU datapath writeback (write port) and the ALU operand fetch (read ports A and B).
//   Entry 0 is hardwired to zero, as in the CPU ISA.
// PARAMETERS
//   WIDTH   8   data bits per entry
//   DEPTH   8   number of entries; must be a power of two, >= 2
//   ADDR_W  3   address bits; must equal log2(DEPTH)
// PORTS
//   clk      in   1       single clock; all state updates on the rising edge
//   rst      in   1       synchronous, active-high reset
//   we       in   1       write enable, sampled on the rising edge of clk
//   waddr    in   ADDR_W  write address
//   wdata    in   WIDTH   write data
//   raddr_a  in   ADDR_W  read address, port A
//   rdata_a  out  WIDTH   read data, port A
//   raddr_b  in   ADDR_W  read address, port B
//   rdata_b  out  WIDTH   read data, port B
// BEHAVIOUR
//   - Clock and reset: one clock. Reset is synchronous and active-high.
//     At a rising edge with rst=1, every entry becomes 0 and we is ignored.
//   - Outputs after reset: rdata_a = rdata_b = 0 for every address.
//   - Write: at a rising edge with rst=0 and we=1, entry[waddr] <= wdata.
//     With we=0, all entries hold their value indefinitely.
//   - Entry 0: writes to waddr=0 are discarded. Reads of address 0 always return 0.
//   - Read: rdata_x = entry[raddr_x], purely combinational from stored state.
//     Zero clock latency. The value changes only when raddr_x or the addressed entry changes.
//   - Read-during-write, same address: no bypass.
//     Before the edge the read returns the old value; the new value appears after the edge.
//   - Both read ports may address the same entry, including the write target; both return the same value.
//   - Address range: every ADDR_W code is a valid entry. There is no out-of-range case and no wrap logic.
//   - Storage element setup:
//       master latch enable = ~clk, slave latch enable = clk.
//       The slave output Q is the stored bit.
//       The master D input = rst ? 0 : (we & addr hit & addr!=0) ? wdata bit : slave Q (hold recirculation).
//   - Reset mid-operation: rst with we=1 in the same cycle -> the whole file is cleared and the write is lost.
//   - No X on outputs after the first reset edge. Before the first reset edge, contents are undefined.
// STRUCTURE
//   - Shared include cpu_defs.vh: REG_WIDTH, REG_DEPTH, REG_ADDR_W, and REG_ZERO (the index of the zero register).
//   - Sub-module d_flip_flop (D, clk, Q): two dLatch instances in master-slave form.
//     reg_file instantiates WIDTH*(DEPTH-1) of them in generate loops.
//   - Remaining logic in reg_file:
//       write decoder (ADDR_W -> DEPTH one-hot, gated by we),
//       per-entry hold/load/clear muxing,
//       two DEPTH:1 read muxes with entry 0 tied to 0.
// TESTING
//   1. Reset: hold rst=1 for one edge after random writes -> all 8 addresses read 0x00 on both ports.
//   2. Write/read: write 0xA5 to addr 3 and 0x5A to addr 6 -> raddr_a=3 gives 0xA5, raddr_b=6 gives 0x5A, same cycle.
//   3. Zero register: we=1, waddr=0, wdata=0xFF -> rdata_a at raddr_a=0 stays 0x00.
//   4. Read-during-write: entry 2 holds 0x11; write 0x22 to addr 2 with raddr_a=2 -> reads 0x11 before the edge, 0x22 after it.
//   5. Hold: write 0x3C to addr 5, then we=0 for 10 cycles while wdata toggles -> addr 5 stays 0x3C.
//   6. Reset wins: rst=1 and we=1 (waddr=4, wdata=0x99) at the same edge -> addr 4 reads 0x00.
//      Then a write of 0x99 with rst=0 -> addr 4 reads 0x99.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared register-file constants for the CPU datapath.
// REG_ZERO is the architectural zero register: always reads 0 and ignores writes.
package reg_file_pkg;

  localparam int REG_WIDTH  = 8;
  localparam int REG_DEPTH  = 8;
  localparam int REG_ADDR_W = 3;
  localparam int REG_ZERO   = 0;

endpackage

// File: rtl/reg_file_d_flip_flop.sv
// Storage primitives for the register file.
// dLatch: a level-sensitive D latch that is transparent while en is high.
// d_flip_flop: a rising-edge flip-flop built from two latches in master-slave form.
//   The master is open while clk is low and the slave is open while clk is high.
//   The slave output is the stored bit.

module dLatch (
  input  logic en,
  input  logic d,
  output logic q
);

  // Follow d while enabled and hold the last value while disabled.
  always_latch begin
    if (en) q <= d;
  end

endmodule

module d_flip_flop (
  input  logic d,
  input  logic clk,
  output logic q
);

  logic clk_n;
  logic master_q;

  assign clk_n = ~clk;

  dLatch u_master (
    .en (clk_n),
    .d  (d),
    .q  (master_q)
  );

  dLatch u_slave (
    .en (clk),
    .d  (master_q),
    .q  (q)
  );

endmodule

// File: rtl/reg_file.sv
// Register file between CPU writeback (write port) and ALU operand fetch (read ports A and B).
// Entry 0 is the hardwired zero register, so it gets no storage.
// Every other bit is a master-slave flip-flop whose D input is chosen here.
// Clear has priority over load, and load has priority over hold.
// The read ports are plain combinational muxes, so a write to the address being read
// is not bypassed. The new value shows up only after the clock edge.

module reg_file
  import reg_file_pkg::*;
#(
  parameter int WIDTH  = REG_WIDTH,
  parameter int DEPTH  = REG_DEPTH,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b
);

  logic [DEPTH-1:1]             write_sel;
  logic [DEPTH-1:1][WIDTH-1:0]  entry_d;
  logic [DEPTH-1:0][WIDTH-1:0]  entry_q;

  // One-hot write decoder gated by we; the zero register has no select line.
  always_comb begin
    write_sel = '0;
    for (int i = 1; i < DEPTH; i++) begin
      write_sel[i] = we && (waddr == ADDR_W'(i));
    end
  end

  // Per-entry next value: clear on reset, load on a write hit, otherwise recirculate.
  always_comb begin
    entry_d = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (rst) begin
        entry_d[i] = '0;
      end else if (write_sel[i]) begin
        entry_d[i] = wdata;
      end else begin
        entry_d[i] = entry_q[i];
      end
    end
  end

  assign entry_q[REG_ZERO] = '0;

  for (genvar e = 1; e < DEPTH; e++) begin : g_entry
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      d_flip_flop u_ff (
        .d   (entry_d[e][b]),
        .clk (clk),
        .q   (entry_q[e][b])
      );
    end
  end

  assign rdata_a = entry_q[raddr_a];
  assign rdata_b = entry_q[raddr_b];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file.
// A behavioural array model is checked against both read ports on every cycle once
// reset has defined the contents. Directed scenarios add hand-computed literal checks.
// Inputs change on the falling edge. Outputs are sampled a few ns later, before the rising edge.

module tb_reg_file;

  logic       clk;
  logic       rst;
  logic       we;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic [2:0] raddr_a;
  logic [7:0] rdata_a;
  logic [2:0] raddr_b;
  logic [7:0] rdata_b;

  int vectors;
  int miscompares;

  logic [7:0] model_mem [8];
  logic       model_valid;

  reg_file dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (raddr_a),
    .rdata_a (rdata_a),
    .raddr_b (raddr_b),
    .rdata_b (rdata_b)
  );

  // Free-running clock with a 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: reset clears everything, and writes to address 0 are dropped.
  initial begin
    model_valid = 1'b0;
    for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;
      model_valid = 1'b1;
    end else if (we && waddr != 3'd0) begin
      model_mem[waddr] = wdata;
    end
  end

  // Compare both read ports against the model every cycle once contents are defined.
  always @(negedge clk) begin
    #2;
    if (model_valid) begin
      vectors++;
      if (rdata_a !== model_mem[raddr_a]) begin
        miscompares++;
        $display("[TB] FAIL model_a[%0d]: got 0x%02h, expected 0x%02h", raddr_a, rdata_a, model_mem[raddr_a]);
      end
      vectors++;
      if (rdata_b !== model_mem[raddr_b]) begin
        miscompares++;
        $display("[TB] FAIL model_b[%0d]: got 0x%02h, expected 0x%02h", raddr_b, rdata_b, model_mem[raddr_b]);
      end
    end
  end

  // Drive one cycle of inputs on the falling edge, then let the read paths settle.
  task automatic applyStimulus(input logic r, input logic w, input logic [2:0] wa,
                               input logic [7:0] wd, input logic [2:0] ra, input logic [2:0] rb);
    @(negedge clk);
    rst     = r;
    we      = w;
    waddr   = wa;
    wdata   = wd;
    raddr_a = ra;
    raddr_b = rb;
    #3;
  endtask

  // Compare one observed value against a hand-computed expectation.
  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;

    // Reset after some random writes clears every entry.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b1, 3'($urandom_range(1, 7)), 8'($urandom), 3'd0, 3'd0);
    applyStimulus(1'b1, 1'b1, 3'd5, 8'hEE, 3'd0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i));
      checkOutput("reset_a", rdata_a, 8'h00);
      checkOutput("reset_b", rdata_b, 8'h00);
    end

    // Basic writes, with both ports reading in the same cycle.
    applyStimulus(1'b0, 1'b1, 3'd3, 8'hA5, 3'd0, 3'd0);
    applyStimulus(1'b0, 1'b1, 3'd6, 8'h5A, 3'd0, 3'd0);
    applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd6);
    checkOutput("write_a3", rdata_a, 8'hA5);
    checkOutput("write_b6", rdata_b, 8'h5A);

    // Zero register ignores writes.
    applyStimulus(1'b0, 1'b1, 3'd0, 8'hFF, 3'd0, 3'd3);
    checkOutput("zero_before", rdata_a, 8'h00);
    applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    checkOutput("zero_after_a", rdata_a, 8'h00);
    checkOutput("zero_after_b", rdata_b, 8'h00);

    // Read during write returns the old value until the edge, with no bypass.
    applyStimulus(1'b0, 1'b1, 3'd2, 8'h11, 3'd0, 3'd0);
    applyStimulus(1'b0, 1'b1, 3'd2, 8'h22, 3'd2, 3'd2);
    checkOutput("rdw_before_a", rdata_a, 8'h11);
    checkOutput("rdw_before_b", rdata_b, 8'h11);
    applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd2);
    checkOutput("rdw_after_a", rdata_a, 8'h22);
    checkOutput("rdw_after_b", rdata_b, 8'h22);

    // Hold across ten idle cycles while wdata toggles.
    applyStimulus(1'b0, 1'b1, 3'd5, 8'h3C, 3'd0, 3'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 3'd5, (i % 2 == 0) ? 8'hFF : 8'h00, 3'd5, 3'd3);
      checkOutput("hold_a5", rdata_a, 8'h3C);
    end
    checkOutput("hold_b3", rdata_b, 8'hA5);

    // Highest address with all ones.
    applyStimulus(1'b0, 1'b1, 3'd7, 8'hFF, 3'd0, 3'd0);
    applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 3'd7, 3'd7);
    checkOutput("top_a7", rdata_a, 8'hFF);
    checkOutput("top_b7", rdata_b, 8'hFF);

    // Reset wins over a simultaneous write, and a later write is accepted.
    applyStimulus(1'b1, 1'b1, 3'd4, 8'h99, 3'd4, 3'd3);
    applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd3);
    checkOutput("rstwin_a4", rdata_a, 8'h00);
    checkOutput("rstwin_b3", rdata_b, 8'h00);
    applyStimulus(1'b0, 1'b1, 3'd4, 8'h99, 3'd0, 3'd0);
    applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd7);
    checkOutput("rewrite_a4", rdata_a, 8'h99);
    checkOutput("rewrite_b7", rdata_b, 8'h00);

    applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    @(negedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
